// File: rtl/nnet_stub_core_if.sv
// Input-sample and result-word stream channels between nnet_stub_core and its wrapper.
// The core uses the slave view; whatever feeds and drains it uses the master view.
interface nnet_stub_core_if;
  logic [31:0] data_V_V_TDATA;
  logic        data_V_V_TVALID;
  logic        data_V_V_TREADY;
  logic [31:0] res_V_V_TDATA;
  logic        res_V_V_TVALID;
  logic        res_V_V_TREADY;

  modport master (
    output data_V_V_TDATA,
    output data_V_V_TVALID,
    input  data_V_V_TREADY,
    input  res_V_V_TDATA,
    input  res_V_V_TVALID,
    output res_V_V_TREADY
  );

  modport slave (
    input  data_V_V_TDATA,
    input  data_V_V_TVALID,
    output data_V_V_TREADY,
    output res_V_V_TDATA,
    output res_V_V_TVALID,
    input  res_V_V_TREADY
  );
endinterface

// File: rtl/nnet_stub_core.sv
// Stand-in for the HLS neural-net core: accumulates one input vector (sum, max, argmax)
// and streams a fixed-length result vector back, cycle-accurate to the real core's handshakes.
module nnet_stub_core #(
  parameter int unsigned SIZE_IN  = 128,
  parameter int unsigned SIZE_OUT = 4
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  output logic [15:0]     const_size_in,
  output logic [15:0]     const_size_out,
  nnet_stub_core_if.slave axis
);

  // state | meaning
  // LOAD  | accept SIZE_IN samples, update acc / max / idx on each transfer
  // EMIT  | present result word out_cnt; advance only on an output transfer
  typedef enum logic {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  localparam logic [15:0] LP_IN_LAST  = 16'(SIZE_IN - 1);
  localparam logic [15:0] LP_OUT_LAST = 16'(SIZE_OUT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_live;
  logic [15:0]        r_in_cnt;
  logic [15:0]        r_out_cnt;
  logic [15:0]        r_idx;
  logic signed [31:0] r_acc;
  logic signed [15:0] r_max;

  logic signed [15:0] w_sample;
  logic signed [31:0] w_sample_ext;
  logic               w_in_rdy;
  logic               w_out_vld;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_last_in;
  logic               w_last_out;
  logic               w_first;
  logic [15:0]        w_acc_sat;
  logic [15:0]        w_word;
  logic               w_unused_hi;

  assign const_size_in  = 16'(SIZE_IN);
  assign const_size_out = 16'(SIZE_OUT);

  assign w_sample     = axis.data_V_V_TDATA[15:0];
  assign w_sample_ext = {{16{w_sample[15]}}, w_sample};
  assign w_unused_hi  = ^axis.data_V_V_TDATA[31:16];

  assign w_last_in  = (r_in_cnt == LP_IN_LAST);
  assign w_last_out = (r_out_cnt == LP_OUT_LAST);
  assign w_first    = (r_in_cnt == 16'd0);
  assign w_in_xfer  = w_in_rdy && axis.data_V_V_TVALID;
  assign w_out_xfer = w_out_vld && axis.res_V_V_TREADY;

  always_comb begin
    if (r_acc > 32'sd32767) begin
      w_acc_sat = 16'h7FFF;
    end else if (r_acc < -32'sd32768) begin
      w_acc_sat = 16'h8000;
    end else begin
      w_acc_sat = r_acc[15:0];
    end
  end

  // r_live keeps TREADY low for the cycle in which reset is released.
  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    w_out_vld   = 1'b0;
    w_word      = 16'h0000;
    case (r_state)
      S_LOAD: begin
        w_in_rdy = r_live;
        if (r_live && axis.data_V_V_TVALID && w_last_in) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        w_out_vld = 1'b1;
        case (r_out_cnt)
          16'd0:   w_word = w_acc_sat;
          16'd1:   w_word = r_max;
          16'd2:   w_word = r_idx;
          default: w_word = 16'h0000;
        endcase
        if (axis.res_V_V_TREADY && w_last_out) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  assign axis.data_V_V_TREADY = w_in_rdy;
  assign axis.res_V_V_TVALID  = w_out_vld;
  assign axis.res_V_V_TDATA   = {16'h0000, w_word};

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state   <= S_LOAD;
      r_live    <= 1'b0;
      r_in_cnt  <= 16'd0;
      r_out_cnt <= 16'd0;
      r_acc     <= 32'sd0;
      r_max     <= 16'sd0;
      r_idx     <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_in_xfer) begin
        r_acc <= r_acc + w_sample_ext;
        // strict compare: a tie keeps the earlier index
        if (w_first || (w_sample > r_max)) begin
          r_max <= w_sample;
          r_idx <= r_in_cnt;
        end
        r_in_cnt <= w_last_in ? 16'd0 : r_in_cnt + 16'd1;
      end
      if (w_out_xfer) begin
        if (w_last_out) begin
          r_out_cnt <= 16'd0;
          r_acc     <= 32'sd0;
          r_max     <= 16'sd0;
          r_idx     <= 16'd0;
        end else begin
          r_out_cnt <= r_out_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nnet_stub_core.sv
// Bench for nnet_stub_core: two instances (4 in / 6 out and 4 in / 3 out) share one input
// stream; each has its own monitor and sum/max/argmax reference model over accepted samples.
module tb_nnet_stub_core;

  logic        ap_clk = 1'b0;
  logic        rst_n;
  logic [31:0] tb_tdata;
  logic        tb_tvalid;
  logic        tb_rready;
  logic [15:0] ca_in, ca_out, cb_in, cb_out;

  int          n_vec = 0;
  int          n_err = 0;
  int          part_a[$], part_b[$];
  int          exp_a[$], exp_b[$];
  int          vec_done_a = 0;
  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [31:0] held_a, held_b;

  always #5 ap_clk = ~ap_clk;

  nnet_stub_core_if if_a ();
  nnet_stub_core_if if_b ();

  assign if_a.data_V_V_TDATA  = tb_tdata;
  assign if_a.data_V_V_TVALID = tb_tvalid;
  assign if_a.res_V_V_TREADY  = tb_rready;
  assign if_b.data_V_V_TDATA  = tb_tdata;
  assign if_b.data_V_V_TVALID = tb_tvalid;
  assign if_b.res_V_V_TREADY  = tb_rready;

  nnet_stub_core #(.SIZE_IN(4), .SIZE_OUT(6)) u_a (
    .ap_clk         (ap_clk),
    .ap_rst_n       (rst_n),
    .const_size_in  (ca_in),
    .const_size_out (ca_out),
    .axis           (if_a)
  );

  nnet_stub_core #(.SIZE_IN(4), .SIZE_OUT(3)) u_b (
    .ap_clk         (ap_clk),
    .ap_rst_n       (rst_n),
    .const_size_in  (cb_in),
    .const_size_out (cb_out),
    .axis           (if_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Result word k of a 4-sample vector, straight from the arithmetic definition.
  function automatic int calc_word(input int s[4], input int k);
    int sum, mx, ix;
    sum = 0;
    mx  = s[0];
    ix  = 0;
    for (int i = 0; i < 4; i++) begin
      sum += s[i];
      if (s[i] > mx) begin
        mx = s[i];
        ix = i;
      end
    end
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
    case (k)
      0:       return sum & 32'hFFFF;
      1:       return mx & 32'hFFFF;
      2:       return ix;
      default: return 0;
    endcase
  endfunction

  always @(negedge ap_clk) begin
    int s4[4];
    if (!rst_n) begin
      part_a.delete();
      exp_a.delete();
      stall_a = 1'b0;
    end else begin
      check("a_in_cnt_bound", 32'(u_a.r_in_cnt <= 16'd3), 1);
      check("a_out_cnt_bound", 32'(u_a.r_out_cnt <= 16'd5), 1);
      if (stall_a) begin
        check("a_stall_vld", if_a.res_V_V_TVALID, 1);
        check("a_stall_data", if_a.res_V_V_TDATA, held_a);
      end
      stall_a = if_a.res_V_V_TVALID && !if_a.res_V_V_TREADY;
      held_a  = if_a.res_V_V_TDATA;
      if (if_a.data_V_V_TVALID && if_a.data_V_V_TREADY) begin
        part_a.push_back(int'($signed(if_a.data_V_V_TDATA[15:0])));
        if (part_a.size() == 4) begin
          foreach (s4[i]) s4[i] = part_a[i];
          for (int k = 0; k < 6; k++) exp_a.push_back(calc_word(s4, k));
          part_a.delete();
          vec_done_a++;
        end
      end
      if (if_a.res_V_V_TVALID && if_a.res_V_V_TREADY) begin
        check("a_word_pending", 32'(exp_a.size() > 0), 1);
        if (exp_a.size() > 0) check("a_word", if_a.res_V_V_TDATA, exp_a.pop_front());
      end
    end
  end

  always @(negedge ap_clk) begin
    int s4[4];
    if (!rst_n) begin
      part_b.delete();
      exp_b.delete();
      stall_b = 1'b0;
    end else begin
      check("b_in_cnt_bound", 32'(u_b.r_in_cnt <= 16'd3), 1);
      check("b_out_cnt_bound", 32'(u_b.r_out_cnt <= 16'd2), 1);
      if (stall_b) begin
        check("b_stall_vld", if_b.res_V_V_TVALID, 1);
        check("b_stall_data", if_b.res_V_V_TDATA, held_b);
      end
      stall_b = if_b.res_V_V_TVALID && !if_b.res_V_V_TREADY;
      held_b  = if_b.res_V_V_TDATA;
      if (if_b.data_V_V_TVALID && if_b.data_V_V_TREADY) begin
        part_b.push_back(int'($signed(if_b.data_V_V_TDATA[15:0])));
        if (part_b.size() == 4) begin
          foreach (s4[i]) s4[i] = part_b[i];
          for (int k = 0; k < 3; k++) exp_b.push_back(calc_word(s4, k));
          part_b.delete();
        end
      end
      if (if_b.res_V_V_TVALID && if_b.res_V_V_TREADY) begin
        check("b_word_pending", 32'(exp_b.size() > 0), 1);
        if (exp_b.size() > 0) check("b_word", if_b.res_V_V_TDATA, exp_b.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send(input int s);
    check("send_in_rdy", if_a.data_V_V_TREADY, 1);
    tb_tdata  = {16'hA5C3, 16'(s)};
    tb_tvalid = 1'b1;
    tick();
  endtask

  // Called in the first EMIT cycle with TREADY high; expects one word per cycle.
  task automatic drain_a(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                         input bit chk_b);
    logic [15:0] e;
    for (int k = 0; k < 6; k++) begin
      e = (k == 0) ? w0 : (k == 1) ? w1 : (k == 2) ? w2 : 16'h0000;
      check("a_emit_vld", if_a.res_V_V_TVALID, 1);
      check("a_emit_word", if_a.res_V_V_TDATA, {16'h0000, e});
      check("a_emit_in_rdy", if_a.data_V_V_TREADY, 0);
      if (chk_b && k < 3) check("b_emit_word", if_b.res_V_V_TDATA, {16'h0000, e});
      if (chk_b && k == 3) begin
        check("b_reload_rdy", if_b.data_V_V_TREADY, 1);
        check("b_reload_vld", if_b.res_V_V_TVALID, 0);
      end
      tick();
    end
    check("a_reload_rdy", if_a.data_V_V_TREADY, 1);
    check("a_reload_vld", if_a.res_V_V_TVALID, 0);
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    tb_tvalid = 1'b0;
    tb_tdata  = 32'h0;
    tb_rready = 1'b1;
    repeat (3) tick();
    check("rst_in_rdy", if_a.data_V_V_TREADY, 0);
    check("rst_res_vld", if_a.res_V_V_TVALID, 0);
    check("rst_res_data", if_a.res_V_V_TDATA, 0);
    check("rst_const_in", ca_in, 16'd4);
    check("rst_const_out", ca_out, 16'd6);
    check("rst_b_const_in", cb_in, 16'd4);
    check("rst_b_const_out", cb_out, 16'd3);
    rst_n = 1'b1;
    check("rel_in_rdy_low", if_a.data_V_V_TREADY, 0);
    tick();
    check("rel_in_rdy_high", if_a.data_V_V_TREADY, 1);

    // 5, -2, 7, 7: sum 17, max 7, first index 2
    send(5); send(-2); send(7); send(7);
    tb_tvalid = 1'b0;
    drain_a(16'h0011, 16'h0007, 16'h0002, 1'b1);

    send(30000); send(30000); send(1); send(0);
    tb_tvalid = 1'b0;
    drain_a(16'h7FFF, 16'h7530, 16'h0000, 1'b0);

    repeat (4) send(-32768);
    tb_tvalid = 1'b0;
    drain_a(16'h8000, 16'h8000, 16'h0000, 1'b0);

    // output stall with a pending input sample that must not be taken
    tb_rready = 1'b0;
    send(1); send(2); send(3); send(4);
    tb_tdata = 32'h0000_0063;
    for (int i = 0; i < 5; i++) begin
      check("stall_vld", if_a.res_V_V_TVALID, 1);
      check("stall_word", if_a.res_V_V_TDATA, 32'h0000_000A);
      check("stall_in_rdy", if_a.data_V_V_TREADY, 0);
      tick();
    end
    tb_tvalid = 1'b0;
    tb_rready = 1'b1;
    drain_a(16'h000A, 16'h0004, 16'h0003, 1'b0);

    // reset after two of four samples
    send(9); send(8);
    tb_tvalid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_rdy_low", if_a.data_V_V_TREADY, 0);
    tick();
    repeat (4) send(1);
    tb_tvalid = 1'b0;
    drain_a(16'h0004, 16'h0001, 16'h0000, 1'b0);

    // reset while results are pending
    tb_rready = 1'b0;
    send(2); send(3); send(-1); send(3);
    tb_tvalid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tb_rready = 1'b1;
    check("emitrst_vld", if_a.res_V_V_TVALID, 0);
    tick();
    send(-1); send(3); send(2); send(3);
    tb_tvalid = 1'b0;
    drain_a(16'h0007, 16'h0003, 16'h0001, 1'b0);

    // random gaps on both sides over 100 vectors of instance a
    cyc = 0;
    begin
      int base;
      base = vec_done_a;
      while (vec_done_a < base + 100 && cyc < 5000) begin
        tb_tvalid = ($urandom_range(0, 9) < 7);
        tb_tdata  = $urandom();
        if ($urandom_range(0, 3) == 0) tb_tdata[15:0] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
        tb_rready = ($urandom_range(0, 9) < 7);
        tick();
        cyc++;
      end
    end
    check("rand_vectors_done", 32'(cyc < 5000), 1);

    tb_tvalid = 1'b0;
    tb_rready = 1'b1;
    cyc = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("drain_pending", exp_a.size() + exp_b.size(), 0);
    tick();
    check("end_in_rdy", if_a.data_V_V_TREADY, 1);
    check("end_res_vld", if_a.res_V_V_TVALID, 0);
    check("end_const_in", ca_in, 16'd4);
    check("end_const_out", ca_out, 16'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nnet_stub_core.md
NNET_STUB_CORE -- requirements
Module: nnet_stub_core

Purpose: cycle-accurate stand-in for the HLS neural-net core behind nnet_vector_wrapper. Consumes one input vector, emits one result vector, and drives the size indicators, so the wrapper and noc_block integration can be tested without HLS output.

Interface
REQ-001 Parameter SIZE_IN, default 128: input samples per vector; legal range 1..65535.
REQ-002 Parameter SIZE_OUT, default 4: output words per vector; legal range 1..65535.
REQ-003 ap_clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-004 ap_rst_n  in  1  reset; synchronous, active-low.
REQ-005 const_size_in  out  16  constant SIZE_IN.
REQ-006 const_size_out  out  16  constant SIZE_OUT.
REQ-007 data_V_V_TDATA  in  32  input sample; bits[15:0] are signed two's complement, bits[31:16] are ignored.
REQ-008 data_V_V_TVALID  in  1  input sample valid.
REQ-009 data_V_V_TREADY  out  1  core accepts the input sample.
REQ-010 res_V_V_TDATA  out  32  result word; bits[31:16] are always 0.
REQ-011 res_V_V_TVALID  out  1  result word valid.
REQ-012 res_V_V_TREADY  in  1  downstream accepts the result word.

Function
REQ-013 A transfer occurs on any edge where TVALID and TREADY are both 1; there is no other transfer condition.
REQ-014 FSM states: LOAD and EMIT. Reset enters LOAD.
REQ-015 LOAD behaviour:
- data_V_V_TREADY = 1, res_V_V_TVALID = 0.
- Input count in_cnt (16 bits) increments on each input transfer.
REQ-016 LOAD accumulation, per input transfer of sample s:
- acc (32-bit signed) += sign-extended s.
- If s > max, or this is the first sample of the vector: max <= s and idx <= in_cnt.
- A tie with the current max leaves max and idx unchanged, so idx is the first index of the maximum.
REQ-017 LOAD to EMIT: on the transfer where in_cnt == SIZE_IN-1, the FSM moves to EMIT on the next edge; in_cnt clears to 0.
REQ-018 EMIT behaviour:
- data_V_V_TREADY = 0 and res_V_V_TVALID = 1.
- Word out_cnt is presented on res_V_V_TDATA.
- The first word appears in the cycle immediately after the last input transfer, i.e. a latency of 1 cycle.
REQ-019 Word content by out_cnt (bits[15:0]):
- 0: acc saturated to the 16-bit range [-32768, 32767].
- 1: max.
- 2: idx.
- 3 and above: 16'h0000.
- If SIZE_OUT < 3, only words 0..SIZE_OUT-1 are emitted.
REQ-020 Stall rules:
- res_V_V_TDATA and res_V_V_TVALID hold stable while res_V_V_TREADY = 0.
- out_cnt advances only on an output transfer, so with TREADY held high, one word is emitted per cycle.
REQ-021 EMIT to LOAD: on the transfer where out_cnt == SIZE_OUT-1, the FSM returns to LOAD on the next edge. At that edge out_cnt, acc, max and idx clear, and data_V_V_TREADY is 1 in the following cycle.
REQ-022 Input TVALID asserted during EMIT is not consumed; no input sample is ever dropped or double-counted.
REQ-023 Accumulator overflow: acc wraps modulo 2^32. This cannot occur for SIZE_IN <= 65535 with 16-bit samples.
REQ-024 const_size_in and const_size_out are constant from configuration and are unaffected by reset.

Reset
REQ-025 When ap_rst_n = 0 at an edge:
- state <= LOAD.
- in_cnt, out_cnt, acc, max, idx <= 0.
- res_V_V_TVALID <= 0, res_V_V_TDATA <= 0.
- data_V_V_TREADY <= 0.
REQ-026 data_V_V_TREADY returns to 1 in the first cycle after ap_rst_n = 1 is sampled.
REQ-027 Reset mid-vector, in either state, discards the partial vector. The next input sample after reset is index 0.

Verification
REQ-028 SIZE_IN=4, SIZE_OUT=3; inputs 5, -2, 7, 7, TREADY=1 -> outputs 0x0011, 0x0007, 0x0002 on 3 consecutive cycles; the first appears 1 cycle after the 4th input transfer.
REQ-029 SIZE_IN=4; inputs 30000, 30000, 1, 0 -> word 0 = 0x7FFF (saturated), word 1 = 0x7530, word 2 = 0x0000. With inputs -32768 ×4 -> word 0 = 0x8000.
REQ-030 res_V_V_TREADY held 0 for 5 cycles during EMIT -> TDATA and TVALID stable; no word is skipped; data_V_V_TREADY stays 0 throughout.
REQ-031 ap_rst_n=0 for 1 cycle after 2 of 4 inputs, then a full vector 1, 1, 1, 1 -> word 0 = 0x0004, idx = 0.
REQ-032 Random TVALID/TREADY gaps over 100 vectors -> outputs match the reference model, and in_cnt and out_cnt never exceed SIZE_IN-1 and SIZE_OUT-1.
REQ-033 SIZE_OUT=6 -> words 3..5 = 0x0000; const_size_in and const_size_out read 4 and 6, including during reset.
